// File: rtl/addr_fifo_pkg.sv
// Shared types and constants for the address FIFO stage.
// Optional feature macro: ADDR_FIFO_HWM_EN (high-water-mark output on addr_fifo_stage).
package addr_fifo_pkg;

  // Consumer-side mode of the FIFO: pops are only allowed while RUN.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } fifo_state_e;

  localparam int DEFAULT_DEPTH = 1024;
  localparam int PTR_W         = $clog2(DEFAULT_DEPTH);

  // Reset value the control block loads into addr_fifo_threshold.
  localparam logic [15:0] DEFAULT_ADDR_THRESHOLD = 16'd820;

endpackage

// File: rtl/sync_fifo_mem.sv
// Dual-port storage array: synchronous write port, asynchronous (show-ahead) read port.
module sync_fifo_mem
  import addr_fifo_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DATA_W = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: store the pushed word at the write pointer.
  // NOTE: the array has no reset; its contents are only read behind a valid occupancy count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/addr_fifo_stage.sv
// Address FIFO between the driver control registers and the vector engine.
// Host pushes address words; the engine pops them over valid/ready while the stage is in RUN.
// Optional feature macro: ADDR_FIFO_HWM_EN adds the hwm (high-water mark) output.
module addr_fifo_stage
  import addr_fifo_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  input  logic              program_start,
  input  logic              active_program,
  input  logic              freeze,
  input  logic              flush,
  input  logic [15:0]       threshold,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              overrun,
  output logic              underrun,
  output logic [CNT_W-1:0]  words_in_fifo,
  output logic [CNT_W-1:0]  addr_cycle_cnt
`ifdef ADDR_FIFO_HWM_EN
  ,
  output logic [CNT_W-1:0]  hwm
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CMP_W = (AW + 1 > 16) ? AW + 1 : 16;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  fifo_state_e      state_q, state_d;
  logic             overrun_q, overrun_d;
  logic             underrun_q, underrun_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             pop;
  logic             push;
  logic             mem_we;

  // Flags come straight from the registered occupancy.
  assign full          = (count_q == FULL_CNT);
  assign empty         = (count_q == '0);
  assign almost_full   = (CMP_W'(count_q) >= CMP_W'(threshold));
  assign words_in_fifo = CNT_W'(count_q);

  assign rd_valid = !empty && (state_q == RUN);
  assign pop      = rd_valid && rd_ready;
  assign push     = wr_en && (!full || pop);
  assign mem_we   = push && !flush;

  assign overrun        = overrun_q;
  assign underrun       = underrun_q;
  assign addr_cycle_cnt = cyc_q;

  sync_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  // Next-state for the consumer mode: active_program gates everything, freeze toggles RUN/FROZEN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (active_program) state_d = RUN;
      RUN:     if (!active_program) state_d = IDLE;
               else if (freeze)     state_d = FROZEN;
      FROZEN:  if (!active_program) state_d = IDLE;
               else if (!freeze)    state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Pointer and occupancy update; flush wins over any push or pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + (AW + 1)'(1);
      else if (pop && !push) count_d = count_q - (AW + 1)'(1);
    end
  end

  // Sticky error flags and stall counter; program_start clears them ahead of any set.
  always_comb begin
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    cyc_d      = cyc_q;
    if (program_start) begin
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
      cyc_d      = '0;
    end else begin
      if (wr_en && full && !pop && !flush)      overrun_d  = 1'b1;
      if ((state_q == RUN) && rd_ready && empty) underrun_d = 1'b1;
      if (state_q == RUN) begin
        if (pop)               cyc_d = '0;
        else if (cyc_q != '1)  cyc_d = cyc_q + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
      cyc_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
      cyc_q      <= cyc_d;
    end
  end

`ifdef ADDR_FIFO_HWM_EN
  logic [CNT_W-1:0] hwm_q, hwm_d;

  // High-water mark tracks the largest registered occupancy; flush leaves it alone.
  always_comb begin
    hwm_d = hwm_q;
    if (program_start)              hwm_d = '0;
    else if (words_in_fifo > hwm_q) hwm_d = words_in_fifo;
  end

  // High-water mark register.
  always_ff @(posedge clk) begin
    if (!reset) hwm_q <= '0;
    else        hwm_q <= hwm_d;
  end

  assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_addr_fifo_stage.sv
// Self-checking bench for addr_fifo_stage: directed sequences, a threshold vector table and
// randomized traffic, all compared against a queue-based reference model.
module tb_addr_fifo_stage;

  localparam int DEPTH   = 1024;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_FROZEN = 2;

  logic              clk;
  logic              reset;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              program_start;
  logic              active_program;
  logic              freeze;
  logic              flush;
  logic [15:0]       threshold;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              overrun;
  logic              underrun;
  logic [CNT_W-1:0]  words_in_fifo;
  logic [CNT_W-1:0]  addr_cycle_cnt;
`ifdef ADDR_FIFO_HWM_EN
  logic [CNT_W-1:0]  hwm;
`endif

  addr_fifo_stage #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .rd_data        (rd_data),
    .program_start  (program_start),
    .active_program (active_program),
    .freeze         (freeze),
    .flush          (flush),
    .threshold      (threshold),
    .full           (full),
    .empty          (empty),
    .almost_full    (almost_full),
    .overrun        (overrun),
    .underrun       (underrun),
    .words_in_fifo  (words_in_fifo),
    .addr_cycle_cnt (addr_cycle_cnt)
`ifdef ADDR_FIFO_HWM_EN
    ,
    .hwm            (hwm)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a queue, mode as a small integer, counters as plain ints.
  logic [DATA_W-1:0] mq[$];
  int m_mode;
  bit m_over;
  bit m_under;
  int m_cyc;
  int m_hwm;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model's current view.
  task automatic model_check();
    int n;
    bit v;
    n = mq.size();
    v = (m_mode == M_RUN) && (n > 0);
    check("words_in_fifo", 64'(words_in_fifo), 64'(n));
    check("empty", 64'(empty), 64'(n == 0));
    check("full", 64'(full), 64'(n == DEPTH));
    check("almost_full", 64'(almost_full), 64'(n >= int'(threshold)));
    check("rd_valid", 64'(rd_valid), 64'(v));
    if (v) check("rd_data", 64'(rd_data), 64'(mq[0]));
    check("overrun", 64'(overrun), 64'(m_over));
    check("underrun", 64'(underrun), 64'(m_under));
    check("addr_cycle_cnt", 64'(addr_cycle_cnt), 64'(m_cyc));
`ifdef ADDR_FIFO_HWM_EN
    check("hwm", 64'(hwm), 64'(m_hwm));
`endif
  endtask

  // Advance one clock: evaluate the rules on pre-edge state and inputs, then commit.
  task automatic tick();
    int n;
    bit pop;
    n   = mq.size();
    pop = (m_mode == M_RUN) && (n > 0) && rd_ready;
    @(posedge clk);
    if (!reset) begin
      mq.delete();
      m_mode  = M_IDLE;
      m_over  = 0;
      m_under = 0;
      m_cyc   = 0;
      m_hwm   = 0;
    end else begin
      if (program_start) begin
        m_hwm = 0; m_over = 0; m_under = 0; m_cyc = 0;
      end else begin
        if (n > m_hwm) m_hwm = n;
        if (wr_en && n == DEPTH && !pop && !flush) m_over = 1;
        if (m_mode == M_RUN && rd_ready && n == 0) m_under = 1;
        if (m_mode == M_RUN) m_cyc = pop ? 0 : ((m_cyc < CNT_MAX) ? m_cyc + 1 : m_cyc);
      end
      if (flush) begin
        mq.delete();
      end else begin
        if (pop) void'(mq.pop_front());
        if (wr_en && (n < DEPTH || pop)) mq.push_back(wr_data);
      end
      if (!active_program)                 m_mode = M_IDLE;
      else if (m_mode == M_IDLE)           m_mode = M_RUN;
      else if (m_mode == M_RUN && freeze)  m_mode = M_FROZEN;
      else if (m_mode == M_FROZEN && !freeze) m_mode = M_RUN;
    end
    #1;
  endtask

  task automatic cycle();
    tick();
    model_check();
  endtask

  task automatic quiet_inputs();
    wr_en = 0; wr_data = '0; rd_ready = 0; program_start = 0; flush = 0; freeze = 0;
  endtask

  task automatic push_n(input int n, input logic [DATA_W-1:0] base);
    wr_en = 1;
    for (int i = 0; i < n; i++) begin
      wr_data = base + DATA_W'(i);
      cycle();
    end
    wr_en = 0;
  endtask

  task automatic do_flush();
    flush = 1; cycle(); flush = 0;
  endtask

  task automatic pulse_start();
    program_start = 1; cycle(); program_start = 0;
  endtask

  typedef struct {
    int          n_push;
    logic [15:0] thr;
    bit          exp_af;
    bit          exp_empty;
    bit          exp_full;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [CNT_W-1:0] held;
    bit over_before;

    vecs[0] = '{0,  16'd0,   1'b1, 1'b1, 1'b0};
    vecs[1] = '{0,  16'd1,   1'b0, 1'b1, 1'b0};
    vecs[2] = '{3,  16'd4,   1'b0, 1'b0, 1'b0};
    vecs[3] = '{4,  16'd4,   1'b1, 1'b0, 1'b0};
    vecs[4] = '{5,  16'd4,   1'b1, 1'b0, 1'b0};
    vecs[5] = '{1,  16'd820, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{10, 16'd10,  1'b1, 1'b0, 1'b0};
    vecs[7] = '{10, 16'd11,  1'b0, 1'b0, 1'b0};

    quiet_inputs();
    active_program = 0;
    threshold = 16'd820;
    reset = 0;
    tick(); tick();
    reset = 1;
    #1;
    check("reset_words", 64'(words_in_fifo), 64'd0);
    check("reset_empty", 64'(empty), 64'd1);
    check("reset_rd_valid", 64'(rd_valid), 64'd0);
    check("reset_almost_full", 64'(almost_full), 64'd0);
    check("reset_cycle_cnt", 64'(addr_cycle_cnt), 64'd0);
    model_check();

    // 1: pushes held while IDLE, then drained in order; underrun appears after empty.
    push_n(1, 32'hA); push_n(1, 32'hB); push_n(1, 32'hC);
    check("t1_words", 64'(words_in_fifo), 64'd3);
    check("t1_rd_valid_idle", 64'(rd_valid), 64'd0);
    active_program = 1; rd_ready = 1;
    cycle();
    check("t1_pop_a", 64'(rd_data), 64'hA); cycle();
    check("t1_pop_b", 64'(rd_data), 64'hB); cycle();
    check("t1_pop_c", 64'(rd_data), 64'hC); cycle();
    check("t1_empty", 64'(empty), 64'd1);
    check("t1_underrun_not_yet", 64'(underrun), 64'd0);
    cycle();
    check("t1_underrun", 64'(underrun), 64'd1);

    // 2: fill to DEPTH, overflow by one, drain and verify order without the dropped word.
    rd_ready = 0; active_program = 0; cycle();
    pulse_start();
    push_n(DEPTH, 32'h1000_0000);
    check("t2_full", 64'(full), 64'd1);
    push_n(1, 32'hDEAD_BEEF);
    check("t2_overrun", 64'(overrun), 64'd1);
    check("t2_words", 64'(words_in_fifo), 64'd1024);
    active_program = 1; cycle();
    rd_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      check("t2_order", 64'(rd_data), 64'(32'h1000_0000 + i));
      cycle();
    end
    check("t2_drained", 64'(empty), 64'd1);
    rd_ready = 0;
    pulse_start();
    check("t2_overrun_cleared", 64'(overrun), 64'd0);

    // 3: full FIFO in RUN, simultaneous push and pop keeps it full; new word lands last.
    push_n(DEPTH, 32'h2000_0000);
    wr_en = 1; wr_data = 32'h5A5A_5A5A; rd_ready = 1;
    cycle();
    wr_en = 0; rd_ready = 0;
    check("t3_full", 64'(full), 64'd1);
    check("t3_words", 64'(words_in_fifo), 64'd1024);
    check("t3_no_overrun", 64'(overrun), 64'd0);
    rd_ready = 1;
    for (int i = 0; i < DEPTH - 1; i++) cycle();
    check("t3_last_word", 64'(rd_data), 64'h5A5A_5A5A);
    cycle();
    rd_ready = 0;

    // 4: almost_full threshold table (filled while IDLE so nothing drains).
    active_program = 0; cycle();
    foreach (vecs[k]) begin
      do_flush();
      push_n(vecs[k].n_push, 32'h3000_0000);
      threshold = vecs[k].thr;
      #1;
      check($sformatf("t4_af[%0d]", k), 64'(almost_full), 64'(vecs[k].exp_af));
      check($sformatf("t4_empty[%0d]", k), 64'(empty), 64'(vecs[k].exp_empty));
      check($sformatf("t4_full[%0d]", k), 64'(full), 64'(vecs[k].exp_full));
    end
    threshold = 16'd4;
    do_flush();
    push_n(3, 32'h3100_0000);
    check("t4_af_at_3", 64'(almost_full), 64'd0);
    wr_en = 1; wr_data = 32'h3100_0003; tick(); wr_en = 0;
    check("t4_af_after_4th", 64'(almost_full), 64'd1);
    threshold = 16'd820;

    // 5: freeze halts pops and the stall counter; release resumes; empty FIFO saturates counter.
    do_flush();
    push_n(10, 32'h4000_0000);
    active_program = 1; cycle(); cycle(); cycle();
    freeze = 1; cycle();
    rd_ready = 1;
    held = addr_cycle_cnt;
    for (int i = 0; i < 20; i++) cycle();
    check("t5_frozen_words", 64'(words_in_fifo), 64'd10);
    check("t5_frozen_cnt", 64'(addr_cycle_cnt), 64'(held));
    freeze = 0; cycle(); cycle();
    check("t5_resumed_words", 64'(words_in_fifo), 64'd9);
    check("t5_cnt_cleared", 64'(addr_cycle_cnt), 64'd0);
    rd_ready = 0;
    do_flush();
    pulse_start();
    for (int i = 0; i < CNT_MAX - 1; i++) tick();
    check("t5_cnt_fffe", 64'(addr_cycle_cnt), 64'hFFFE);
    tick();
    check("t5_cnt_ffff", 64'(addr_cycle_cnt), 64'hFFFF);
    tick();
    check("t5_cnt_saturated", 64'(addr_cycle_cnt), 64'hFFFF);
    model_check();

    // 6: flush with concurrent push empties the FIFO, keeps sticky flags and high-water mark.
    active_program = 0; cycle();
    pulse_start();
    push_n(5, 32'h6000_0000);
    over_before = m_over;
    wr_en = 1; wr_data = 32'h6666_6666; flush = 1;
    cycle();
    wr_en = 0; flush = 0;
    check("t6_words", 64'(words_in_fifo), 64'd0);
    check("t6_empty", 64'(empty), 64'd1);
    check("t6_overrun_kept", 64'(overrun), 64'(over_before));
`ifdef ADDR_FIFO_HWM_EN
    check("t6_hwm", 64'(hwm), 64'd5);
    cycle();
    check("t6_hwm_kept", 64'(hwm), 64'd5);
`endif

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      wr_en          = ($urandom_range(0, 99) < 55);
      wr_data        = $urandom;
      rd_ready       = ($urandom_range(0, 99) < 50);
      freeze         = ($urandom_range(0, 99) < 10);
      flush          = ($urandom_range(0, 99) < 3);
      program_start  = ($urandom_range(0, 99) < 3);
      threshold      = 16'($urandom_range(0, 20));
      reset          = !($urandom_range(0, 999) < 3);
      if ($urandom_range(0, 99) < 5) active_program = !active_program;
      cycle();
    end
    quiet_inputs();
    reset = 1;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/addr_fifo_stage.md
Name: addr_fifo_stage

Overview:
Address FIFO stage directly downstream of the driver control register block. Accepts host-written address words (addr_fifo_wr/addr_fifo_din) and buffers them for the vector engine over a valid/ready pop port. Returns occupancy, flags, sticky error bits and a stall-cycle counter to the control block's status registers.

Parameters:
DEPTH, 1024, FIFO entries; power of two, at least 4.
DATA_W, 32, address word width.
CNT_W, 16, width of the occupancy and cycle-count outputs; must satisfy CNT_W > log2(DEPTH).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
wr_en  in  1  push strobe (addr_fifo_wr)
wr_data  in  DATA_W  push data (addr_fifo_din)
rd_valid  out  1  head entry available to consumer
rd_ready  in  1  consumer accepts head
rd_data  out  DATA_W  head entry
program_start  in  1  single-cycle pulse; clears sticky flags and cycle count
active_program  in  1  program running
freeze  in  1  blocks pops (freeze_addr_fifo)
flush  in  1  empties FIFO (driven from abort_program)
threshold  in  16  almost-full level (addr_fifo_threshold)
full  out  1  occupancy == DEPTH
empty  out  1  occupancy == 0
almost_full  out  1  occupancy >= threshold
overrun  out  1  sticky: push attempted while full
underrun  out  1  sticky: pop requested while empty during RUN
words_in_fifo  out  CNT_W  current occupancy
addr_cycle_cnt  out  CNT_W  saturating count of cycles since last pop, RUN only

Behaviour:
- Reset (reset==0 at a clk edge): pointers 0; words_in_fifo 0; empty 1; full 0; almost_full 1 if threshold==0, else 0; overrun/underrun 0; addr_cycle_cnt 0; rd_valid 0; state IDLE. Memory contents are don't-care.
- Storage: DEPTH x DATA_W array; write and read pointers of log2(DEPTH) bits wrap naturally; separate occupancy counter, log2(DEPTH)+1 bits wide, zero-extended onto words_in_fifo.
- rd_data = mem[rd_ptr], read asynchronously from registered pointer (show-ahead); content valid only while rd_valid.
- rd_valid = !empty && state==RUN; pop = rd_valid && rd_ready.
- Push accepted when wr_en && (!full || pop) → mem[wr_ptr] <= wr_data; wr_ptr++.
- wr_en && full && !pop: data dropped, overrun <= 1.
- Push and pop in the same cycle: occupancy unchanged. Pop from a FIFO holding one entry with a simultaneous push is legal; the new word is visible the next cycle.
- Flags full/empty/almost_full are combinational from the registered occupancy, so every flag updates one cycle after the push or pop that changes it.
- FSM states: IDLE, RUN, FROZEN.
  - IDLE→RUN when active_program==1.
  - RUN→FROZEN when freeze==1; FROZEN→RUN when freeze==0.
  - RUN or FROZEN→IDLE when active_program==0.
  - IDLE and FROZEN block pops; pushes are accepted in all states.
- underrun <= 1 when state==RUN && rd_ready && empty.
- addr_cycle_cnt:
  - RUN: cleared to 0 on pop; otherwise incremented, saturating at all-ones.
  - IDLE and FROZEN: holds value.
- program_start: clears overrun, underrun and addr_cycle_cnt. It takes priority over a same-cycle set, so flags read 0 the following cycle.
- flush: pointers and occupancy return to 0 next cycle; a same-cycle push is discarded without setting overrun; sticky flags are unaffected; flush has priority over push and pop.
- Priority order: reset > flush > push/pop.

Optional Feature:
Macro: ADDR_FIFO_HWM_EN
- Defined: adds output port hwm (CNT_W bits), the high-water mark. It holds the maximum words_in_fifo seen, updated each cycle. It clears to 0 on reset and on program_start; on flush it keeps its value.
- Undefined: no hwm port and no related logic.

Decomposition:
- Shared package addr_fifo_pkg:
  - fsm state enum (IDLE, RUN, FROZEN);
  - localparam PTR_W = $clog2(DEPTH);
  - DEFAULT_ADDR_THRESHOLD = 820.
- One sub-module, sync_fifo_mem: dual-port array with a synchronous write port and an asynchronous read port.
- Pointer, count, flag and FSM logic live in addr_fifo_stage.

Test Plan:
1. Reset, then threshold=820, 3 pushes 0xA,0xB,0xC with active_program=0 → words_in_fifo=3, rd_valid=0. Raise active_program, rd_ready=1 → pops 0xA,0xB,0xC on consecutive cycles, then empty=1, underrun=1 from the cycle after empty.
2. Push DEPTH words, then one more → full=1, overrun=1, words_in_fifo=1024. Pop all → data matches order with the dropped word absent; program_start pulse → overrun=0.
3. Full FIFO in RUN, push and pop the same cycle → full stays 1, words=1024, new word appears last.
4. threshold=4: push 3 → almost_full=0; push 4th → almost_full=1 the next cycle. threshold=0 → almost_full=1 when empty.
5. RUN with 10 words, freeze=1 for 20 cycles → no pops, addr_cycle_cnt frozen. Release freeze → pops resume. With an empty FIFO, addr_cycle_cnt saturates at 0xFFFF after 65535 cycles.
6. 5 words, flush with concurrent wr_en → words_in_fifo=0, empty=1, overrun unchanged. With ADDR_FIFO_HWM_EN defined, hwm=5 retained across the flush.
